// File: rtl/centroid_pkg.sv
// Shared types and constants for the multi-channel centroid engine:
// FSM state encoding, default widths and bounding-box empty values.
package centroid_pkg;

   localparam int COORD_X_W = 11;
   localparam int COORD_Y_W = 10;
   localparam int PIX_CNT_W = 20;

   // An empty bounding box has min at all-ones and max at zero, so the first
   // pixel always wins both comparisons.
   localparam logic [31:0] BBOX_MIN_EMPTY = '1;
   localparam logic [31:0] BBOX_MAX_EMPTY = '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DIV  = 2'd2,
      ST_EMIT = 2'd3
   } cm_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The first bit is
// produced on the start edge, so done is high during the W-th cycle after start.
module seq_divider #(
   parameter int W   = 31,
   parameter int Q_W = 11
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   dividend,
   input  logic [W-1:0]   divisor,
   output logic           done,
   output logic [Q_W-1:0] quotient
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  rem_q;
   logic [W-1:0]  quo_q;
   logic [W-1:0]  dsr_q;
   logic [CW-1:0] cnt_q;
   logic          active_q;

   logic [W-1:0]  src_rem;
   logic [W-1:0]  src_quo;
   logic [W-1:0]  src_dsr;
   logic [W:0]    shifted;
   logic [W:0]    diff;
   logic [W-1:0]  nxt_rem;
   logic [W-1:0]  nxt_quo;

   // A set borrow bit (diff[W]) means the trial subtraction went negative.
   always_comb begin
      src_rem = start ? '0 : rem_q;
      src_quo = start ? dividend : quo_q;
      src_dsr = start ? divisor : dsr_q;
      shifted = {src_rem, src_quo[W-1]};
      diff    = shifted - {1'b0, src_dsr};
      if (diff[W]) begin
         nxt_rem = shifted[W-1:0];
         nxt_quo = {src_quo[W-2:0], 1'b0};
      end else begin
         nxt_rem = diff[W-1:0];
         nxt_quo = {src_quo[W-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_q    <= '0;
         quo_q    <= '0;
         dsr_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (start) begin
         rem_q    <= nxt_rem;
         quo_q    <= nxt_quo;
         dsr_q    <= divisor;
         cnt_q    <= CW'(W - 1);
         active_q <= 1'b1;
      end else if (active_q) begin
         if (cnt_q != '0) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            cnt_q <= cnt_q - CW'(1);
         end else begin
            active_q <= 1'b0;
         end
      end
   end

   assign done     = active_q && (cnt_q == '0);
   assign quotient = quo_q[Q_W-1:0];

endmodule

// File: rtl/multi_center_of_mass.sv
// Multi-channel centroid engine: per-channel coordinate accumulation, frame
// snapshot on a tabulate edge, serial divide/emit per channel. Optional bbox: CENTROID_BBOX_EN.
module multi_center_of_mass
   import centroid_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int X_W       = COORD_X_W,
   parameter int Y_W       = COORD_Y_W,
   parameter int CNT_W     = PIX_CNT_W,
   parameter int MIN_COUNT = 16,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic [X_W-1:0]    x_in,
   input  logic [Y_W-1:0]    y_in,
   input  logic [NUM_CH-1:0] mask_in,
   input  logic              valid_in,
   input  logic              tabulate_in,
   output logic [CH_W-1:0]   ch_out,
   output logic [X_W-1:0]    x_out,
   output logic [Y_W-1:0]    y_out,
   output logic [CNT_W-1:0]  count_out,
   output logic              found_out,
   output logic              valid_out,
   output logic              frame_done_out,
   output logic              busy_out,
   output logic              overrun_out
`ifdef CENTROID_BBOX_EN
   ,
   output logic [X_W-1:0]    x_min_out,
   output logic [X_W-1:0]    x_max_out,
   output logic [Y_W-1:0]    y_min_out,
   output logic [Y_W-1:0]    y_max_out
`endif
);

   localparam int XS_W  = X_W + CNT_W;
   localparam int YS_W  = Y_W + CNT_W;
   localparam int DIV_W = X_W + CNT_W;

   logic [XS_W-1:0]  x_sum     [NUM_CH];
   logic [YS_W-1:0]  y_sum     [NUM_CH];
   logic [CNT_W-1:0] pix_cnt   [NUM_CH];
   logic [XS_W-1:0]  snap_x    [NUM_CH];
   logic [YS_W-1:0]  snap_y    [NUM_CH];
   logic [CNT_W-1:0] snap_cnt  [NUM_CH];
`ifdef CENTROID_BBOX_EN
   logic [X_W-1:0]   x_min     [NUM_CH];
   logic [X_W-1:0]   x_max     [NUM_CH];
   logic [Y_W-1:0]   y_min     [NUM_CH];
   logic [Y_W-1:0]   y_max     [NUM_CH];
   logic [X_W-1:0]   snap_xmin [NUM_CH];
   logic [X_W-1:0]   snap_xmax [NUM_CH];
   logic [Y_W-1:0]   snap_ymin [NUM_CH];
   logic [Y_W-1:0]   snap_ymax [NUM_CH];
`endif

   cm_state_e        state_q, state_d;
   logic [CH_W-1:0]  ch_q;
   logic             tab_prev;
   logic             tab_edge;
   logic             accept;
   logic [NUM_CH-1:0] hit;
   logic [CNT_W-1:0] cur_cnt;
   logic             cur_found;
   logic             last_ch;
   logic             start_div;
   logic             x_done, y_done, div_done;
   logic [X_W-1:0]   x_quo;
   logic [Y_W-1:0]   y_quo;

   assign tab_edge  = tabulate_in && !tab_prev;
   assign accept    = tab_edge && (state_q == ST_IDLE);
   assign hit       = valid_in ? mask_in : '0;
   assign cur_cnt   = snap_cnt[ch_q];
   assign cur_found = (cur_cnt != '0) && (cur_cnt >= CNT_W'(MIN_COUNT));
   assign last_ch   = (ch_q == CH_W'(NUM_CH - 1));
   assign div_done  = x_done && y_done;

   // On an accepted edge the current-cycle pixel seeds the new frame rather
   // than being added to the snapshot being closed.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         for (int c = 0; c < NUM_CH; c++) begin
            x_sum[c]     <= '0;
            y_sum[c]     <= '0;
            pix_cnt[c]   <= '0;
            snap_x[c]    <= '0;
            snap_y[c]    <= '0;
            snap_cnt[c]  <= '0;
`ifdef CENTROID_BBOX_EN
            x_min[c]     <= BBOX_MIN_EMPTY[X_W-1:0];
            x_max[c]     <= BBOX_MAX_EMPTY[X_W-1:0];
            y_min[c]     <= BBOX_MIN_EMPTY[Y_W-1:0];
            y_max[c]     <= BBOX_MAX_EMPTY[Y_W-1:0];
            snap_xmin[c] <= BBOX_MIN_EMPTY[X_W-1:0];
            snap_xmax[c] <= BBOX_MAX_EMPTY[X_W-1:0];
            snap_ymin[c] <= BBOX_MIN_EMPTY[Y_W-1:0];
            snap_ymax[c] <= BBOX_MAX_EMPTY[Y_W-1:0];
`endif
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (accept) begin
               snap_x[c]   <= x_sum[c];
               snap_y[c]   <= y_sum[c];
               snap_cnt[c] <= pix_cnt[c];
               x_sum[c]    <= hit[c] ? XS_W'(x_in) : '0;
               y_sum[c]    <= hit[c] ? YS_W'(y_in) : '0;
               pix_cnt[c]  <= hit[c] ? CNT_W'(1) : '0;
`ifdef CENTROID_BBOX_EN
               snap_xmin[c] <= x_min[c];
               snap_xmax[c] <= x_max[c];
               snap_ymin[c] <= y_min[c];
               snap_ymax[c] <= y_max[c];
               x_min[c] <= hit[c] ? x_in : BBOX_MIN_EMPTY[X_W-1:0];
               x_max[c] <= hit[c] ? x_in : BBOX_MAX_EMPTY[X_W-1:0];
               y_min[c] <= hit[c] ? y_in : BBOX_MIN_EMPTY[Y_W-1:0];
               y_max[c] <= hit[c] ? y_in : BBOX_MAX_EMPTY[Y_W-1:0];
`endif
            end else if (hit[c] && (pix_cnt[c] != '1)) begin
               x_sum[c]   <= x_sum[c] + XS_W'(x_in);
               y_sum[c]   <= y_sum[c] + YS_W'(y_in);
               pix_cnt[c] <= pix_cnt[c] + CNT_W'(1);
`ifdef CENTROID_BBOX_EN
               if (x_in < x_min[c]) x_min[c] <= x_in;
               if (x_in > x_max[c]) x_max[c] <= x_in;
               if (y_in < y_min[c]) y_min[c] <= y_in;
               if (y_in > y_max[c]) y_max[c] <= y_in;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q     <= ST_IDLE;
         ch_q        <= '0;
         tab_prev    <= 1'b1;
         overrun_out <= 1'b0;
      end else begin
         state_q     <= state_d;
         tab_prev    <= tabulate_in;
         overrun_out <= tab_edge && (state_q != ST_IDLE);
         if (accept)
            ch_q <= '0;
         else if ((state_q == ST_EMIT) && !last_ch)
            ch_q <= ch_q + CH_W'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      start_div = 1'b0;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = ST_LOAD;
         ST_LOAD: begin
            if (cur_found) begin
               start_div = 1'b1;
               state_d   = ST_DIV;
            end else begin
               state_d = ST_EMIT;
            end
         end
         ST_DIV:  if (div_done) state_d = ST_EMIT;
         ST_EMIT: state_d = last_ch ? ST_IDLE : ST_LOAD;
         default: state_d = ST_IDLE;
      endcase
   end

   seq_divider #(.W(DIV_W), .Q_W(X_W)) u_div_x (
      .clk      (clk_in),
      .rst_n    (rst_n_in),
      .start    (start_div),
      .dividend (DIV_W'(snap_x[ch_q])),
      .divisor  (DIV_W'(cur_cnt)),
      .done     (x_done),
      .quotient (x_quo)
   );

   seq_divider #(.W(DIV_W), .Q_W(Y_W)) u_div_y (
      .clk      (clk_in),
      .rst_n    (rst_n_in),
      .start    (start_div),
      .dividend (DIV_W'(snap_y[ch_q])),
      .divisor  (DIV_W'(cur_cnt)),
      .done     (y_done),
      .quotient (y_quo)
   );

   // Result registers load on entry to EMIT and hold until the next EMIT.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         x_out     <= '0;
         y_out     <= '0;
         count_out <= '0;
         found_out <= 1'b0;
`ifdef CENTROID_BBOX_EN
         x_min_out <= '0;
         x_max_out <= '0;
         y_min_out <= '0;
         y_max_out <= '0;
`endif
      end else if (((state_q == ST_LOAD) && !cur_found) ||
                   ((state_q == ST_DIV) && div_done)) begin
         x_out     <= (state_q == ST_DIV) ? x_quo : '0;
         y_out     <= (state_q == ST_DIV) ? y_quo : '0;
         found_out <= (state_q == ST_DIV);
         count_out <= cur_cnt;
`ifdef CENTROID_BBOX_EN
         x_min_out <= snap_xmin[ch_q];
         x_max_out <= snap_xmax[ch_q];
         y_min_out <= snap_ymin[ch_q];
         y_max_out <= snap_ymax[ch_q];
`endif
      end
   end

   assign ch_out         = ch_q;
   assign valid_out      = (state_q == ST_EMIT);
   assign frame_done_out = (state_q == ST_EMIT) && last_ch;
   assign busy_out       = (state_q != ST_IDLE);

endmodule
